// File: rtl/mem_pkg.sv
// Shared constants for the data-memory load/store master: funct3 codes, sign_mask encodings, FSM states.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // bits[2:0] select the byte lanes, bit3 asks the memory to sign-extend
    localparam logic [3:0] SM_BYTE   = 4'b0001;
    localparam logic [3:0] SM_HALF   = 4'b0011;
    localparam logic [3:0] SM_WORD   = 4'b0111;
    localparam logic [3:0] SM_SIGNED = 4'b1000;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        LOAD_DATA  = 3'd2,
        STORE_WAIT = 3'd3,
        RESP       = 3'd4
    } state_e;

endpackage

// File: rtl/mem_req_decode.sv
// Combinational request decode: funct3/store/addr[1:0] -> sign_mask, illegal, misaligned.
// Zero latency; no flow control of its own.
module mem_req_decode
    import mem_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic [2:0] i_funct3,
    input  logic       i_store,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_sign_mask,
    output logic       o_illegal,
    output logic       o_misaligned
);

    logic w_half;
    logic w_word;

    always_comb begin
        o_sign_mask = 4'b0000;
        o_illegal   = 1'b0;
        if (i_store) begin
            case (i_funct3)
                F3_B:    o_sign_mask = SM_BYTE;
                F3_H:    o_sign_mask = SM_HALF;
                F3_W:    o_sign_mask = SM_WORD;
                default: o_illegal   = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                F3_B:    o_sign_mask = SM_SIGNED | SM_BYTE;
                F3_H:    o_sign_mask = SM_SIGNED | SM_HALF;
                F3_W:    o_sign_mask = SM_WORD;
                F3_BU:   o_sign_mask = SM_BYTE;
                F3_HU:   o_sign_mask = SM_HALF;
                default: o_illegal   = 1'b1;
            endcase
        end
    end

    assign w_half = (o_sign_mask[2:0] == SM_HALF[2:0]);
    assign w_word = (o_sign_mask[2:0] == SM_WORD[2:0]);

    // An illegal funct3 is reported as an error only, never also as misaligned
    assign o_misaligned = CHECK_ALIGN && !o_illegal &&
                          ((w_half && i_addr_lo[0]) || (w_word && (i_addr_lo != 2'b00)));

endmodule

// File: rtl/mem_access_master.sv
// MEM-stage initiator for the data memory: one request in flight, load 3 / store 3+stall / error 1 cycle(s)
// from accept to resp_valid; req_ready only in IDLE, response is a strobe with no backpressure.
module mem_access_master
    import mem_pkg::*;
#(
    parameter int STALL_TIMEOUT = 16,
    parameter bit CHECK_ALIGN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    state_e      r_state;
    state_e      w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_mask;
    logic        r_store;
    logic        r_mis;
    logic        r_err;

    logic [3:0]  w_mask;
    logic        w_illegal;
    logic        w_misaligned;
    logic [8:0]  w_cnt_inc;
    logic        w_timeout;
    logic        w_store_done;

    mem_req_decode #(.CHECK_ALIGN(CHECK_ALIGN)) u_decode (
        .i_funct3     (req_funct3),
        .i_store      (req_store),
        .i_addr_lo    (req_addr[1:0]),
        .o_sign_mask  (w_mask),
        .o_illegal    (w_illegal),
        .o_misaligned (w_misaligned)
    );

    // The memory holds stall for a cycle after the write edge, so a low stall at count 0 is not completion
    assign w_cnt_inc    = {1'b0, r_cnt} + 9'd1;
    assign w_store_done = !mem_clk_stall && (r_cnt != 8'd0);
    assign w_timeout    = mem_clk_stall && (w_cnt_inc >= 9'(STALL_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (req_valid) w_next = (w_illegal || w_misaligned) ? RESP : ISSUE;
            ISSUE:      w_next = r_store ? STORE_WAIT : LOAD_DATA;
            LOAD_DATA:  w_next = RESP;
            STORE_WAIT: if (w_store_done || w_timeout) w_next = RESP;
            RESP:       w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (r_state == IDLE);
        resp_valid   = (r_state == RESP);
        mem_memread  = (r_state == ISSUE) && !r_store;
        mem_memwrite = (r_state == ISSUE) &&  r_store;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 8'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_mask  <= 4'd0;
            r_store <= 1'b0;
            r_mis   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_mask  <= w_mask;
                    r_store <= req_store;
                    r_mis   <= w_misaligned;
                    r_err   <= w_illegal;
                end
                ISSUE:      r_cnt   <= 8'd0;
                LOAD_DATA:  r_rdata <= mem_read_data;
                STORE_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_timeout) r_err <= 1'b1;
                end
                RESP: begin
                    r_cnt   <= 8'd0;
                    r_addr  <= 32'd0;
                    r_wdata <= 32'd0;
                    r_rdata <= 32'd0;
                    r_mask  <= 4'd0;
                    r_store <= 1'b0;
                    r_mis   <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata      = r_rdata;
    assign resp_misaligned = r_mis;
    assign resp_error      = r_err;
    assign mem_addr        = r_addr;
    assign mem_write_data  = r_wdata;
    assign mem_sign_mask   = r_mask;

endmodule

// File: tb/tb_mem_access_master.sv
// Randomized bench for mem_access_master: a byte-array memory responder plus a request-level reference model.
module tb_mem_access_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_misaligned, resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_memwrite, mem_memread, mem_clk_stall;
    logic [3:0]  mem_sign_mask;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];
    int stall_len  = 0;
    int stall_left = 0;
    int rd_hold    = 0;
    int n_rd_env   = 0;
    int n_wr_env   = 0;

    mem_access_master #(.STALL_TIMEOUT(TO), .CHECK_ALIGN(1'b1)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_error      (resp_error),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_memwrite    (mem_memwrite),
        .mem_memread     (mem_memread),
        .mem_sign_mask   (mem_sign_mask),
        .mem_read_data   (mem_read_data),
        .mem_clk_stall   (mem_clk_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] extend(input logic [31:0] raw, input int nb, input bit sgn);
        logic [31:0] r;
        r = raw;
        if (nb == 1)      r = sgn ? {{24{raw[7]}},  raw[7:0]}  : {24'd0, raw[7:0]};
        else if (nb == 2) r = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
        return r;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input int nb);
        for (int i = 0; i < nb; i++) ref_mem[8'(a[7:0] + i)] = wd[8*i +: 8];
    endtask

    // Advance to the next falling edge and play the memory's part for the cycle just observed
    task automatic tick();
        logic [31:0] raw;
        int nb;
        @(negedge clk);
        nb = mem_sign_mask[2] ? 4 : (mem_sign_mask[1] ? 2 : 1);
        if (mem_memread) begin
            raw = 32'd0;
            for (int i = 0; i < nb; i++) raw[8*i +: 8] = env_mem[8'(mem_addr[7:0] + i)];
            mem_read_data = extend(raw, nb, mem_sign_mask[3]);
            rd_hold = 1;
            n_rd_env++;
        end else if (rd_hold > 0) begin
            rd_hold--;
        end else begin
            mem_read_data = $urandom;
        end
        if (mem_memwrite) begin
            for (int i = 0; i < nb; i++) env_mem[8'(mem_addr[7:0] + i)] = mem_write_data[8*i +: 8];
            stall_left    = stall_len;
            mem_clk_stall = 1'b0;
            n_wr_env++;
        end else if (stall_left > 0) begin
            mem_clk_stall = 1'b1;
            stall_left--;
        end else begin
            mem_clk_stall = 1'b0;
        end
    endtask

    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall_n);
        bit legal, mis, sgn, exp_err, seen;
        int nb, exp_lat, lat, rd0, wr0;
        logic [3:0]  exp_sm;
        logic [31:0] exp_rd, raw;

        legal   = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        nb      = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        mis     = legal && ((nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00));
        sgn     = !st && !f3[2] && (nb != 4);
        exp_sm  = ((nb == 1) ? 4'b0001 : (nb == 2) ? 4'b0011 : 4'b0111) | (sgn ? 4'b1000 : 4'b0000);
        exp_rd  = 32'd0;
        exp_err = !legal;
        if (!legal || mis) begin
            exp_lat = 1;
        end else if (!st) begin
            exp_lat = 3;
            raw = 32'd0;
            for (int i = 0; i < nb; i++) raw[8*i +: 8] = ref_mem[8'(addr[7:0] + i)];
            exp_rd = extend(raw, nb, sgn);
        end else begin
            ref_store(addr, wd, nb);
            if (stall_n >= TO) begin
                exp_err = 1'b1;
                exp_lat = TO + 2;
            end else begin
                exp_lat = (stall_n <= 1) ? 4 : 3 + stall_n;
            end
        end

        stall_len = stall_n;
        rd0 = n_rd_env;
        wr0 = n_wr_env;
        chk("ready_before", req_ready, 1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        req_store  = 1'($urandom);

        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            tick();
            lat++;
            if (mem_memread || mem_memwrite) begin
                chk("strobe_mask", mem_sign_mask, exp_sm);
                chk("strobe_addr", mem_addr, addr);
            end
            if (mem_memwrite) chk("strobe_wdata", mem_write_data, wd);
            if (resp_valid) seen = 1'b1;
        end
        chk("resp_seen", seen, 1);
        chk("latency", lat, exp_lat);
        chk("resp_error", resp_error, exp_err);
        chk("resp_misaligned", resp_misaligned, mis);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("n_read", n_rd_env - rd0, (legal && !mis && !st) ? 1 : 0);
        chk("n_write", n_wr_env - wr0, (legal && !mis && st) ? 1 : 0);
        tick();
        chk("ready_after", req_ready, 1);
        chk("valid_after", resp_valid, 0);
        chk("addr_idle", mem_addr, 0);
    endtask

    initial begin
        bit st;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int sn, wr0;

        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_read_data = 32'd0; mem_clk_stall = 1'b0;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        env_mem[8'h10] = 8'hEF; env_mem[8'h11] = 8'hBE; env_mem[8'h12] = 8'hAD; env_mem[8'h13] = 8'hDE;
        for (int i = 16; i < 20; i++) ref_mem[i] = env_mem[i];

        repeat (3) tick();
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", resp_valid, 0);
        chk("rst_memread", mem_memread, 0);
        chk("rst_memwrite", mem_memwrite, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_write_data, 0);
        chk("rst_mask", mem_sign_mask, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_flags", {resp_error, resp_misaligned}, 0);
        reset = 1'b0;

        do_req(1'b0, 3'b010, 32'h0000_0010, 32'd0, 0);
        do_req(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 1);
        do_req(1'b0, 3'b100, 32'h0000_0013, 32'd0, 0);
        do_req(1'b0, 3'b001, 32'h0000_0005, 32'd0, 0);
        do_req(1'b0, 3'b011, 32'h0000_0020, 32'd0, 0);
        do_req(1'b1, 3'b010, 32'h0000_0020, 32'h1234_5678, 1000);
        do_req(1'b1, 3'b010, 32'h0000_2000, 32'h0000_0001, 2);
        do_req(1'b0, 3'b000, 32'h0000_0013, 32'd0, 0);

        // Reset while a store is waiting out its stall
        stall_len = 1000;
        wr0 = n_wr_env;
        wd  = $urandom;
        ref_store(32'h40, wd, 4);
        chk("rstmid_ready", req_ready, 1);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) begin
            tick();
            chk("rstmid_no_resp", resp_valid, 0);
        end
        reset = 1'b1;
        tick();
        chk("rstmid_ready_after", req_ready, 1);
        chk("rstmid_strobes", {mem_memread, mem_memwrite}, 0);
        chk("rstmid_valid", resp_valid, 0);
        chk("rstmid_one_write", n_wr_env - wr0, 1);
        reset = 1'b0;
        do_req(1'b0, 3'b010, 32'h0000_0010, 32'd0, 0);
        do_req(1'b0, 3'b010, 32'h0000_0040, 32'd0, 0);

        for (int n = 0; n < 150; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = {($urandom_range(0, 1) == 1) ? 24'h0 : 24'($urandom), 8'($urandom)};
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            wd = $urandom;
            sn = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 5);
            do_req(st, f3, a, wd, sn);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
